// File: rtl/clk_12_5k_if.sv
// Divider control/output bundle: run enable in, divided clock (and optional tick strobe) out.
// Optional tick strobe present when CLK12_5K_TICK_EN is defined.
interface clk_12_5k_if;
  logic en;
  logic clk12_5k;
`ifdef CLK12_5K_TICK_EN
  logic tick12_5k;

  modport master (input en, output clk12_5k, output tick12_5k);
  modport slave  (output en, input clk12_5k, input tick12_5k);
`else
  modport master (input en, output clk12_5k);
  modport slave  (output en, input clk12_5k);
`endif
endinterface

// File: rtl/clk_12_5k.sv
// Fixed-ratio clock divider: CLK_FREQ_HZ -> OUT_FREQ_HZ square wave, 50 % duty.
// Optional feature macro: CLK12_5K_TICK_EN adds a one-cycle strobe on each output rise.
module clk_12_5k #(
  parameter int unsigned CLK_FREQ_HZ = 100_000_000,
  parameter int unsigned OUT_FREQ_HZ = 12_500
) (
  input  logic       clk,
  input  logic       rst_n,
  clk_12_5k_if.master bus
);

  localparam int unsigned HALF_DIV = CLK_FREQ_HZ / (2 * OUT_FREQ_HZ);
  localparam int unsigned CNT_W    = (HALF_DIV > 1) ? $clog2(HALF_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(HALF_DIV - 1);

  // Reject ratios that cannot produce even a CLK/2 output.
  generate
    if (HALF_DIV < 1) begin : g_bad_ratio
      $error("clk_12_5k: HALF_DIV must be >= 1");
    end
  endgenerate

  logic [CNT_W-1:0] cnt;
  logic             clk_q;
  logic             wrap_c;

  // Half-period boundary reached on this enabled edge.
  assign wrap_c = bus.en && (cnt == CNT_MAX);

  // Half-period counter and output toggle; both hold while disabled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt   <= '0;
      clk_q <= 1'b0;
    end else if (bus.en) begin
      if (cnt == CNT_MAX) begin
        cnt   <= '0;
        clk_q <= ~clk_q;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

  assign bus.clk12_5k = clk_q;

`ifdef CLK12_5K_TICK_EN
  logic tick_q;

  // Strobe on the edge where the output goes low -> high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tick_q <= 1'b0;
    end else begin
      tick_q <= wrap_c && !clk_q;
    end
  end

  assign bus.tick12_5k = tick_q;
`endif

endmodule

// File: tb/tb_clk_12_5k.sv
// Self-checking bench for clk_12_5k: default ratio plus a HALF_DIV=1 instance.
module tb_clk_12_5k;

  localparam int H  = 100_000_000 / (2 * 12_500);
  localparam int H1 = 2 / (2 * 1);

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_mis;
  logic mon_on;

  clk_12_5k_if u_if ();
  clk_12_5k_if u_if1 ();

  clk_12_5k u_dut (.clk(clk), .rst_n(rst_n), .bus(u_if));
  clk_12_5k #(.CLK_FREQ_HZ(2), .OUT_FREQ_HZ(1)) u_dut1 (.clk(clk), .rst_n(rst_n), .bus(u_if1));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_mis++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: count enabled edges since reset; output level and rise
  // strobe follow from plain division by the half period.
  int   e_main, e_h1;
  logic tm_main, tm_h1;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      e_main  <= 0;
      e_h1    <= 0;
      tm_main <= 1'b0;
      tm_h1   <= 1'b0;
    end else begin
      if (u_if.en)  e_main <= e_main + 1;
      if (u_if1.en) e_h1   <= e_h1 + 1;
      tm_main <= u_if.en  && (((e_main + 1) % (2 * H))  == H);
      tm_h1   <= u_if1.en && (((e_h1 + 1)   % (2 * H1)) == H1);
    end
  end

  // Cycle-by-cycle comparison against the model, sampled after the edge.
  always @(posedge clk) begin
    #1;
    if (mon_on) begin
      check("mon_clk",    int'(u_if.clk12_5k),  (e_main / H) % 2);
      check("mon_clk_h1", int'(u_if1.clk12_5k), (e_h1 / H1) % 2);
`ifdef CLK12_5K_TICK_EN
      check("mon_tick",    int'(u_if.tick12_5k),  int'(tm_main));
      check("mon_tick_h1", int'(u_if1.tick12_5k), int'(tm_h1));
`endif
    end
  end

  // Count edges until the main output reaches val; ticks seen along the way.
  task automatic wait_level(input logic val, input int bound, output int n, output int ticks);
    n = 0;
    ticks = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
`ifdef CLK12_5K_TICK_EN
      if (u_if.tick12_5k) ticks++;
`endif
    end while (u_if.clk12_5k !== val && n < bound);
    if (u_if.clk12_5k !== val) check("wait_timeout", 0, 1);
  endtask

  typedef struct {
    logic en;
    logic exp_clk;
    logic exp_tick;
  } vec_t;

  vec_t tbl[10];

  initial begin : watchdog
    #2ms;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int n, n2, t, tk;
    n_cmp  = 0;
    n_mis  = 0;
    mon_on = 1'b1;
    rst_n  = 1'b0;
    u_if.en  = 1'b1;
    u_if1.en = 1'b1;

    tbl[0] = '{1'b1, 1'b1, 1'b1};
    tbl[1] = '{1'b1, 1'b0, 1'b0};
    tbl[2] = '{1'b0, 1'b0, 1'b0};
    tbl[3] = '{1'b1, 1'b1, 1'b1};
    tbl[4] = '{1'b0, 1'b1, 1'b0};
    tbl[5] = '{1'b0, 1'b1, 1'b0};
    tbl[6] = '{1'b1, 1'b0, 1'b0};
    tbl[7] = '{1'b1, 1'b1, 1'b1};
    tbl[8] = '{1'b1, 1'b0, 1'b0};
    tbl[9] = '{1'b0, 1'b0, 1'b0};

    // Reset held for 100 ns with the clock running.
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      check("rst_clk", int'(u_if.clk12_5k), 0);
`ifdef CLK12_5K_TICK_EN
      check("rst_tick", int'(u_if.tick12_5k), 0);
`endif
    end

    // First rise at the H-th edge, fall at the 2H-th.
    rst_n = 1'b1;
    wait_level(1'b1, 3 * H, n, tk);
    check("first_rise_edges", n, H);
`ifdef CLK12_5K_TICK_EN
    check("first_rise_tick", tk, 1);
`endif
    wait_level(1'b0, 3 * H, n2, tk);
    check("first_fall_edges", n + n2, 2 * H);

    // Several full periods: every phase is exactly H cycles, one tick each.
    t = 0;
    for (int p = 0; p < 3; p++) begin
      wait_level(1'b1, 3 * H, n, tk);
      check("low_phase", n, H);
      t += tk;
      wait_level(1'b0, 3 * H, n, tk);
      check("high_phase", n, H);
      t += tk;
    end
`ifdef CLK12_5K_TICK_EN
    check("tick_count", t, 3);
`endif

    // Enable dropped for 100 cycles at cnt=1000 of a low phase.
    for (int i = 0; i < 1000; i++) begin
      @(posedge clk);
      #1;
    end
    u_if.en = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk);
      #1;
`ifdef CLK12_5K_TICK_EN
      if (u_if.tick12_5k !== 1'b0) check("hold_tick", int'(u_if.tick12_5k), 0);
`endif
    end
    check("hold_clk", int'(u_if.clk12_5k), 0);
    u_if.en = 1'b1;
    wait_level(1'b1, 3 * H, n, tk);
    check("stretched_low", 1000 + 100 + n, H + 100);

    // Asynchronous reset mid-high phase, between clock edges.
    for (int i = 0; i < 500; i++) begin
      @(posedge clk);
      #1;
    end
    check("pre_async_high", int'(u_if.clk12_5k), 1);
    #3;
    rst_n = 1'b0;
    #1;
    check("async_rst_clk", int'(u_if.clk12_5k), 0);
    check("async_rst_clk_h1", int'(u_if1.clk12_5k), 0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    wait_level(1'b1, 3 * H, n, tk);
    check("post_rst_rise", n, H);

    // Randomized enables against the model.
    for (int i = 0; i < 10000; i++) begin
      u_if.en  = ($urandom_range(0, 3) != 0);
      u_if1.en = 1'($urandom_range(0, 1));
      @(posedge clk);
      #1;
    end
    u_if.en  = 1'b1;
    u_if1.en = 1'b1;

    // HALF_DIV=1 instance from a fresh reset, table-driven.
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    check("h1_start", int'(u_if1.clk12_5k), 0);
    for (int i = 0; i < 10; i++) begin
      u_if1.en = tbl[i].en;
      @(posedge clk);
      #1;
      check($sformatf("h1_vec%0d_clk", i), int'(u_if1.clk12_5k), int'(tbl[i].exp_clk));
`ifdef CLK12_5K_TICK_EN
      check($sformatf("h1_vec%0d_tick", i), int'(u_if1.tick12_5k), int'(tbl[i].exp_tick));
`else
      if (tbl[i].exp_tick === 1'bx) check("h1_tbl", 0, 1);
`endif
    end

    mon_on = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
